// File: rtl/door_lock_pkg.sv
// Shared keypad constants, column drive codes and key code mapping.
// Used by the matrix scanner and its debouncer.
package door_lock_pkg;

  localparam int KEY_COUNT = 9;
  localparam int KP_ROWS   = 3;
  localparam int KP_COLS   = 3;

  localparam logic [2:0] COL_DRV0 = 3'b110;
  localparam logic [2:0] COL_DRV1 = 3'b101;
  localparam logic [2:0] COL_DRV2 = 3'b011;

  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2
  } col_state_t;

  function automatic logic [3:0] key_to_code(
    input logic [KEY_COUNT-1:0] lvl
  );
    logic [3:0]           code;
    logic [KEY_COUNT-1:0] one;
    code = 4'd0;
    for (int i = 0; i < KEY_COUNT; i++) begin
      one    = '0;
      one[i] = 1'b1;
      if (lvl == one) code = 4'(i + 1);
    end
    return code;
  endfunction

  function automatic logic is_ghost(
    input logic [KEY_COUNT-1:0] lvl
  );
    return $countones(lvl) > 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: a snapshot must repeat DEBOUNCE_SCANS
// consecutive evaluations before it becomes the stable state.
module keypad_debounce
  import door_lock_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [KEY_COUNT-1:0] snapshot,
  input  logic                 eval,
  output logic [KEY_COUNT-1:0] stable,
  output logic [KEY_COUNT-1:0] stable_next
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

  logic [KEY_COUNT-1:0] cand;
  logic [KEY_COUNT-1:0] cand_next;
  logic [CW-1:0]        count;
  logic [CW-1:0]        count_next;

  always_comb begin
    cand_next   = cand;
    count_next  = count;
    stable_next = stable;
    if (eval) begin
      if (snapshot != cand) begin
        cand_next  = snapshot;
        count_next = CW'(1);
      end else if (count < CW'(DEBOUNCE_SCANS)) begin
        count_next = count + 1'b1;
      end
      if (count_next == CW'(DEBOUNCE_SCANS))
        stable_next = cand_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cand   <= '0;
      count  <= '0;
      stable <= '0;
    end else begin
      cand   <= cand_next;
      count  <= count_next;
      stable <= stable_next;
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 3x3 keypad scanner: column drive FSM, row synchronizer, snapshot,
// ghost filter and registered one-hot / code / press-strobe outputs.
module keypad_matrix_scanner
  import door_lock_pkg::*;
#(
  parameter int DWELL_CYCLES   = 24000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [2:0]           KEY_ROW,
  output logic [2:0]           KEY_COL,
  output logic [KEY_COUNT-1:0] key_level,
  output logic [3:0]           key_code,
  output logic                 key_pulse
);

  localparam int DW = $clog2(DWELL_CYCLES);

  col_state_t state;
  col_state_t state_next;
  logic [DW-1:0] dwell;
  logic [DW-1:0] dwell_next;
  logic          last;
  logic          frame_done;
  logic          eval;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= COL0;
      dwell <= '0;
    end else begin
      state <= state_next;
      dwell <= dwell_next;
    end
  end

  always_comb begin
    state_next = state;
    KEY_COL    = COL_DRV0;
    last       = (dwell == DW'(DWELL_CYCLES - 1));
    dwell_next = last ? '0 : dwell + 1'b1;
    unique case (state)
      COL0: begin
        KEY_COL = COL_DRV0;
        if (last) state_next = COL1;
      end
      COL1: begin
        KEY_COL = COL_DRV1;
        if (last) state_next = COL2;
      end
      COL2: begin
        KEY_COL = COL_DRV2;
        if (last) state_next = COL0;
      end
      default: state_next = COL0;
    endcase
    frame_done = last && (state == COL2);
  end

  logic [SYNC_STAGES-1:0][2:0] sync;
  logic [2:0]                  pressed;

  // Idle rows read high, so the chain resets to "nothing pressed"
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync <= '1;
    end else begin
      sync[0] <= KEY_ROW;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync[i] <= sync[i-1];
    end
  end

  assign pressed = ~sync[SYNC_STAGES-1];

  logic [KEY_COUNT-1:0] snapshot;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      snapshot <= '0;
      eval     <= 1'b0;
    end else begin
      eval <= frame_done;
      if (last) begin
        for (int r = 0; r < KP_ROWS; r++)
          for (int c = 0; c < KP_COLS; c++)
            if (state == col_state_t'(c))
              snapshot[r*KP_COLS+c] <= pressed[r];
      end
    end
  end

  logic [KEY_COUNT-1:0] stable;
  logic [KEY_COUNT-1:0] stable_next;
  logic [KEY_COUNT-1:0] level_cur;
  logic [KEY_COUNT-1:0] level_next;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .CLK        (CLK),
    .RESET      (RESET),
    .snapshot   (snapshot),
    .eval       (eval),
    .stable     (stable),
    .stable_next(stable_next)
  );

  assign level_cur  = is_ghost(stable) ? '0 : stable;
  assign level_next = is_ghost(stable_next) ? '0 : stable_next;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      key_level <= '0;
      key_code  <= 4'd0;
      key_pulse <= 1'b0;
    end else begin
      key_level <= level_next;
      key_code  <= key_to_code(level_next);
      key_pulse <= (level_next != '0) &&
                   (level_next != level_cur);
    end
  end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench: a behavioural 3x3 membrane drives KEY_ROW from
// KEY_COL and a pressed-key mask; timing is checked frame by frame.
module tb_keypad_matrix_scanner;

  logic       CLK;
  logic       RESET;
  logic [2:0] KEY_ROW;
  logic [2:0] KEY_COL;
  logic [8:0] key_level;
  logic [3:0] key_code;
  logic       key_pulse;

  logic [8:0] mask;
  int         checks;
  int         failures;
  int         pulses;
  int         p0;

  keypad_matrix_scanner #(
    .DWELL_CYCLES  (4),
    .DEBOUNCE_SCANS(3),
    .SYNC_STAGES   (2)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .KEY_ROW  (KEY_ROW),
    .KEY_COL  (KEY_COL),
    .key_level(key_level),
    .key_code (key_code),
    .key_pulse(key_pulse)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // A pressed key shorts its row low while its column is driven low
  always_comb begin
    KEY_ROW = 3'b111;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (mask[r*3+c] && !KEY_COL[c])
          KEY_ROW[r] = 1'b0;
  end

  always @(negedge CLK)
    if (key_pulse === 1'b1) pulses++;

  task automatic check(
    input string       tag,
    input logic [15:0] got,
    input logic [15:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_frame_start();
    logic [2:0] prev;
    logic       found;
    found = 1'b0;
    prev  = KEY_COL;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(1);
      if (KEY_COL == 3'b110 && prev == 3'b011) found = 1'b1;
      prev = KEY_COL;
    end
    check("frame_sync", 16'(found), 16'd1);
  endtask

  task automatic frame_step(
    input string      tag,
    input logic [8:0] new_mask,
    input logic [8:0] old_lvl,
    input logic [8:0] new_lvl,
    input logic [3:0] new_code,
    input logic       exp_pulse
  );
    wait_frame_start();
    mask = new_mask;
    tick(36);
    check({tag, "_pre"}, 16'(key_level), 16'(old_lvl));
    tick(1);
    check({tag, "_lvl"}, 16'(key_level), 16'(new_lvl));
    check({tag, "_code"}, 16'(key_code), 16'(new_code));
    check({tag, "_pulse"}, 16'(key_pulse), 16'(exp_pulse));
    tick(1);
    check({tag, "_pulse_end"}, 16'(key_pulse), 16'd0);
  endtask

  logic [2:0] col_pat [3];

  initial begin
    checks   = 0;
    failures = 0;
    pulses   = 0;
    mask     = 9'd0;
    RESET    = 1'b1;
    col_pat[0] = 3'b110;
    col_pat[1] = 3'b101;
    col_pat[2] = 3'b011;

    // 1: reset state and idle scanning
    tick(2);
    check("rst_col", 16'(KEY_COL), 16'(3'b110));
    check("rst_lvl", 16'(key_level), 16'd0);
    check("rst_code", 16'(key_code), 16'd0);
    check("rst_pulse", 16'(key_pulse), 16'd0);
    RESET = 1'b0;
    for (int i = 1; i < 24; i++) begin
      tick(1);
      check("idle_col", 16'(KEY_COL), 16'(col_pat[(i/4)%3]));
    end
    tick(24);
    check("idle_lvl", 16'(key_level), 16'd0);
    check("idle_pulses", 16'(pulses), 16'd0);

    // 2: key 5 press and hold
    frame_step("k5", 9'h010, 9'h000, 9'h010, 4'd5, 1'b1);
    p0 = pulses;
    tick(120);
    check("k5_hold_pulses", 16'(pulses - p0), 16'd0);
    check("k5_hold_lvl", 16'(key_level), 16'h010);

    // release before the bounce sequence
    frame_step("k5_rel", 9'h000, 9'h010, 9'h000, 4'd0, 1'b0);

    // 3: bounce for 4 frames, then hold
    wait_frame_start();
    p0 = pulses;
    for (int k = 0; k < 4; k++) begin
      mask = (k % 2 == 0) ? 9'h010 : 9'h000;
      tick(12);
    end
    check("bnc_lvl", 16'(key_level), 16'd0);
    mask = 9'h010;
    tick(36);
    check("bnc_pre", 16'(key_level), 16'd0);
    tick(1);
    check("bnc_lvl_acc", 16'(key_level), 16'h010);
    check("bnc_code", 16'(key_code), 16'd5);
    check("bnc_pulse", 16'(key_pulse), 16'd1);
    tick(1);
    check("bnc_pulses", 16'(pulses - p0), 16'd1);

    // 4: two keys ghost-rejected, then key 9 alone
    frame_step("k19", 9'h101, 9'h010, 9'h000, 4'd0, 1'b0);
    frame_step("k9", 9'h100, 9'h000, 9'h100, 4'd9, 1'b1);

    // 5: release key 9, press key 2
    frame_step("k9_rel", 9'h000, 9'h100, 9'h000, 4'd0, 1'b0);
    frame_step("k2", 9'h002, 9'h000, 9'h002, 4'd2, 1'b1);

    // 6: reset while key 3 is accepted
    frame_step("k3", 9'h004, 9'h002, 9'h004, 4'd3, 1'b1);
    tick(5);
    RESET = 1'b1;
    tick(1);
    check("mrst_lvl", 16'(key_level), 16'd0);
    check("mrst_col", 16'(KEY_COL), 16'(3'b110));
    check("mrst_code", 16'(key_code), 16'd0);
    RESET = 1'b0;
    p0 = pulses;
    tick(36);
    check("mrst_pre", 16'(key_level), 16'd0);
    tick(1);
    check("mrst_code3", 16'(key_code), 16'd3);
    check("mrst_pulse", 16'(key_pulse), 16'd1);
    tick(1);
    check("mrst_pulses", 16'(pulses - p0), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
